// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared encodings and defaults for the two-approach
//                intersection controller: 3-bit state codes, approach
//                direction constants and default phase durations.
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

    // State codes, also presented on the debug phase output
    localparam logic [2:0] PH_GRN   = 3'd0;
    localparam logic [2:0] PH_YEL   = 3'd1;
    localparam logic [2:0] PH_CLR   = 3'd2;
    localparam logic [2:0] PH_PED   = 3'd3;
    localparam logic [2:0] PH_FLASH = 3'd4;

    typedef enum logic [2:0] {
        ST_GRN   = PH_GRN,
        ST_YEL   = PH_YEL,
        ST_CLR   = PH_CLR,
        ST_PED   = PH_PED,
        ST_FLASH = PH_FLASH
    } state_t;

    // Approach served next or currently
    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;

    // Default durations in ticks
    localparam int DEF_CNT_W      = 6;
    localparam int DEF_GREEN_DUR  = 10;
    localparam int DEF_YELLOW_DUR = 3;
    localparam int DEF_CLR_DUR    = 1;
    localparam int DEF_PED_DUR    = 6;

endpackage
`default_nettype wire

// File: rtl/intersection_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Tick-enabled phase counter shared by all phases. Counts
//                ticks since the last clear, flags expiry on the tick where
//                the count reaches dur-1 and reports the ticks remaining.
//  Ports       : clk, rst (async, active-high), tick (timebase enable),
//                clear (restart at 0), dur (phase length, 1..2^CNT_W),
//                expire (tick && cnt == dur-1), remain (dur-1-cnt)
//  Revision    : 1.0  initial release
// ============================================================================
module phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clear,
    input  logic [CNT_W:0]   dur,
    output logic             expire,
    output logic [CNT_W-1:0] remain
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   last;

    // dur is one bit wider than cnt so that a full 2^CNT_W phase fits;
    // the wide compare keeps the top bit meaningful.
    assign last   = dur - 1'b1;
    assign expire = tick && ({1'b0, cnt} == last);
    assign remain = last[CNT_W-1:0] - cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/intersection_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_ctrl
//  Description : Two-approach intersection controller. Cycles the main (A)
//                and side (B) approaches through green, yellow and all-red
//                clearance, inserts pedestrian walk phases on request and
//                offers a night flash mode entered from clearance.
//  Ports       : clk, rst (async, active-high), tick (timebase enable),
//                ped_req[1:0] (crossing requests), flash_mode (night mode),
//                a_red/a_yel/a_grn, b_red/b_yel/b_grn (lamps),
//                walk[1:0] (walk lamps), remain (ticks left in phase),
//                phase (state code, debug)
//  Revision    : 1.0  initial release
// ============================================================================
module intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GREEN_DUR  = DEF_GREEN_DUR,
    parameter int YELLOW_DUR = DEF_YELLOW_DUR,
    parameter int CLR_DUR    = DEF_CLR_DUR,
    parameter int PED_DUR    = DEF_PED_DUR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [1:0]       ped_req,
    input  logic             flash_mode,
    output logic             a_red,
    output logic             a_yel,
    output logic             a_grn,
    output logic             b_red,
    output logic             b_yel,
    output logic             b_grn,
    output logic [1:0]       walk,
    output logic [CNT_W-1:0] remain,
    output logic [2:0]       phase
);

    localparam logic [CNT_W:0] GRN_D = (CNT_W+1)'(GREEN_DUR);
    localparam logic [CNT_W:0] YEL_D = (CNT_W+1)'(YELLOW_DUR);
    localparam logic [CNT_W:0] CLR_D = (CNT_W+1)'(CLR_DUR);
    localparam logic [CNT_W:0] PED_D = (CNT_W+1)'(PED_DUR);

    state_t           state;
    logic             dir;
    logic [1:0]       ped_pend;
    logic [1:0]       ped_serve;
    logic             flash_ph;

    logic [CNT_W:0]   cur_dur;
    logic             expire;
    logic             state_chg;
    logic [CNT_W-1:0] tmr_remain;

    // Duration of the phase currently running; FLASH ignores the timer.
    always_comb begin
        cur_dur = CLR_D;
        case (state)
            ST_GRN:  cur_dur = GRN_D;
            ST_YEL:  cur_dur = YEL_D;
            ST_CLR:  cur_dur = CLR_D;
            ST_PED:  cur_dur = PED_D;
            default: cur_dur = CLR_D;
        endcase
    end

    // The counter restarts on exactly the cycles the FSM changes state.
    always_comb begin
        state_chg = 1'b1;
        case (state)
            ST_GRN, ST_YEL, ST_CLR, ST_PED: state_chg = expire;
            ST_FLASH:                       state_chg = tick && !flash_mode;
            default:                        state_chg = 1'b1;
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .clear  (state_chg),
        .dur    (cur_dur),
        .expire (expire),
        .remain (tmr_remain)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLR;
            dir       <= DIR_A;
            ped_pend  <= 2'b00;
            ped_serve <= 2'b00;
            flash_ph  <= 1'b0;
        end else begin
            // Requests accumulate every clock; PED entry below overrides.
            ped_pend <= ped_pend | ped_req;
            case (state)
                ST_GRN: begin
                    if (expire) state <= ST_YEL;
                end
                ST_YEL: begin
                    if (expire) begin
                        state <= ST_CLR;
                        dir   <= ~dir;
                    end
                end
                ST_CLR: begin
                    if (expire) begin
                        if (flash_mode) begin
                            state    <= ST_FLASH;
                            flash_ph <= 1'b1;
                        end else if ((ped_pend | ped_req) != 2'b00) begin
                            // Same-clock requests are served, not deferred
                            state     <= ST_PED;
                            ped_serve <= ped_pend | ped_req;
                            ped_pend  <= 2'b00;
                        end else begin
                            state <= ST_GRN;
                        end
                    end
                end
                ST_PED: begin
                    if (expire) begin
                        state     <= ST_CLR;
                        ped_serve <= 2'b00;
                    end
                end
                ST_FLASH: begin
                    if (tick) begin
                        if (!flash_mode) begin
                            state    <= ST_CLR;
                            dir      <= DIR_A;
                            flash_ph <= 1'b0;
                        end else begin
                            flash_ph <= ~flash_ph;
                        end
                    end
                end
                default: begin
                    state     <= ST_CLR;
                    dir       <= DIR_A;
                    ped_serve <= 2'b00;
                    flash_ph  <= 1'b0;
                end
            endcase
        end
    end

    // Lamp decode straight from registered state
    always_comb begin
        a_red  = 1'b1;
        a_yel  = 1'b0;
        a_grn  = 1'b0;
        b_red  = 1'b1;
        b_yel  = 1'b0;
        b_grn  = 1'b0;
        walk   = 2'b00;
        remain = tmr_remain;
        case (state)
            ST_GRN: begin
                if (dir == DIR_A) begin
                    a_red = 1'b0;
                    a_grn = 1'b1;
                end else begin
                    b_red = 1'b0;
                    b_grn = 1'b1;
                end
            end
            ST_YEL: begin
                if (dir == DIR_A) begin
                    a_red = 1'b0;
                    a_yel = 1'b1;
                end else begin
                    b_red = 1'b0;
                    b_yel = 1'b1;
                end
            end
            ST_PED: begin
                walk = ped_serve;
            end
            ST_FLASH: begin
                a_red  = 1'b0;
                a_yel  = flash_ph;
                b_red  = flash_ph;
                remain = '0;
            end
            default: begin
            end
        endcase
    end

    assign phase = state;

endmodule
`default_nettype wire
